// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: priority stall vector, timed flush/redirect FSM, stall watchdog.
// Latency: stall is combinational; flush/new_pc appear the cycle after flush_req; no backpressure.
// Define STALL_PERF_COUNT_EN to build the free-running stall-cycle counter behind stall_cycles.
module pipe_ctrl #(
  parameter logic [15:0] STALL_LIMIT  = 16'd1023,
  parameter logic [2:0]  FLUSH_CYCLES = 3'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        stallreq_from_mem,
  input  logic        flush_req,
  input  logic [31:0] new_pc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_flush_cnt;
  logic [31:0] r_new_pc;
  logic [15:0] r_stall_run;
  logic [15:0] w_stall_run_inc;
  logic        r_stall_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A fresh redirect always wins, even over the last cycle of a running flush.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (flush_req) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!flush_req && (r_flush_cnt == 3'd0)) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    flush = 1'b0;
    stall = 6'b000000;
    case (r_state)
      ST_RUN: begin
        if (!rst) begin
          if (stallreq_from_mem) begin
            stall = 6'b011111;
          end else if (stallreq_from_ex) begin
            stall = 6'b001111;
          end else if (stallreq_from_id) begin
            stall = 6'b000111;
          end
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
      end
      default: begin
        flush = 1'b0;
        stall = 6'b000000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= 3'd0;
      r_new_pc    <= 32'h0;
    end else if (flush_req) begin
      r_flush_cnt <= 3'(FLUSH_CYCLES - 3'd1);
      r_new_pc    <= new_pc_i;
    end else if ((r_state == ST_FLUSH) && (r_flush_cnt != 3'd0)) begin
      r_flush_cnt <= r_flush_cnt - 3'd1;
    end
  end

  assign new_pc = r_new_pc;

  assign w_stall_run_inc = (r_stall_run == 16'hFFFF) ? r_stall_run : r_stall_run + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_run     <= 16'd0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_stall_run <= stall[0] ? w_stall_run_inc : 16'd0;
      if (stall[0] && (w_stall_run_inc >= STALL_LIMIT)) begin
        r_stall_timeout <= 1'b1;
      end
    end
  end

  assign stall_timeout = r_stall_timeout;

`ifdef STALL_PERF_COUNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 32'h0;
    end else if (stall[0]) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, corner sequences, randomized run vs reference model.
module tb_pipe_ctrl;

  localparam logic [15:0] LIM = 16'd5;
  localparam logic [2:0]  FC  = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_r, ex_r, mem_r, fr;
  logic [31:0] npc_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        tmo;
  logic [31:0] scyc;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  int          m_left;
  logic [31:0] m_pc;
  int          m_run;
  bit          m_tmo;
  logic [31:0] m_total;

  typedef struct packed {
    logic        id;
    logic        ex;
    logic        mem;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [16];

  pipe_ctrl #(.STALL_LIMIT(LIM), .FLUSH_CYCLES(FC)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (id_r),
    .stallreq_from_ex  (ex_r),
    .stallreq_from_mem (mem_r),
    .flush_req         (fr),
    .new_pc_i          (npc_i),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_timeout     (tmo),
    .stall_cycles      (scyc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_stall(input bit r, input bit i, input bit e, input bit m);
    int n;
    if (r || m_left > 0) return 6'd0;
    n = m ? 5 : (e ? 4 : (i ? 3 : 0));
    return 6'((1 << n) - 1);
  endfunction

  function automatic logic [31:0] exp_scyc();
`ifdef STALL_PERF_COUNT_EN
    return m_total;
`else
    return 32'h0;
`endif
  endfunction

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step();
    logic [5:0] es;
    es = model_stall(rst, id_r, ex_r, mem_r);
    #1;
    chk("rnd_stall", {26'd0, stall}, {26'd0, es});
    @(posedge clk);
    if (es[0]) begin
      m_run = (m_run == 65535) ? m_run : m_run + 1;
      if (m_run >= int'(LIM)) m_tmo = 1'b1;
      m_total = m_total + 32'd1;
    end else begin
      m_run = 0;
    end
    if (fr) begin
      m_left = int'(FC);
      m_pc   = npc_i;
    end else if (m_left > 0) begin
      m_left--;
    end
    #1;
    chk("rnd_flush", {31'd0, flush}, {31'd0, m_left > 0});
    if (m_left > 0) chk("rnd_new_pc", new_pc, m_pc);
    chk("rnd_timeout", {31'd0, tmo}, {31'd0, m_tmo});
    chk("rnd_stall_cycles", scyc, exp_scyc());
  endtask

  task automatic do_reset();
    rst = 1'b1; fr = 1'b0; npc_i = 32'h0;
    id_r = 1'b1; ex_r = 1'b1; mem_r = 1'b1;
    #2;
    chk("rst_stall", {26'd0, stall}, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_timeout", {31'd0, tmo}, 32'h0);
    chk("rst_stall_cycles", scyc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; id_r = 1'b0; ex_r = 1'b0; mem_r = 1'b0;
    m_left = 0; m_pc = 32'h0; m_run = 0; m_tmo = 1'b0; m_total = 32'h0;
  endtask

  initial begin
    rst = 1'b1; id_r = 1'b0; ex_r = 1'b0; mem_r = 1'b0; fr = 1'b0; npc_i = 32'h0;

    //          id ex mem fr pc            stall  flush pc
    tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        6'h00,1'b0,32'h0};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,32'h0,        6'h1F,1'b0,32'h0};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        6'h07,1'b0,32'h0};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        6'h0F,1'b0,32'h0};
    tbl[4]  = '{1'b0,1'b1,1'b0,1'b1,32'hBFC00380, 6'h0F,1'b1,32'hBFC00380};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        6'h00,1'b1,32'hBFC00380};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        6'h00,1'b1,32'hBFC00380};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        6'h00,1'b0,32'h0};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        6'h0F,1'b0,32'h0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,32'h0,        6'h00,1'b0,32'h0};
    tbl[10] = '{1'b0,1'b0,1'b1,1'b1,32'h11111110, 6'h1F,1'b1,32'h11111110};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b1,32'h22222220, 6'h00,1'b1,32'h22222220};
    tbl[12] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        6'h00,1'b1,32'h22222220};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        6'h00,1'b1,32'h22222220};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,32'h0,        6'h00,1'b0,32'h0};
    tbl[15] = '{1'b0,1'b1,1'b0,1'b0,32'h0,        6'h0F,1'b0,32'h0};

    #3;
    do_reset();

    for (int i = 0; i < 16; i++) begin
      id_r = tbl[i].id; ex_r = tbl[i].ex; mem_r = tbl[i].mem;
      fr = tbl[i].fr; npc_i = tbl[i].pc;
      #1;
      chk($sformatf("tbl%0d_stall", i), {26'd0, stall}, {26'd0, tbl[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_flush", i), {31'd0, flush}, {31'd0, tbl[i].e_flush});
      if (tbl[i].e_flush) chk($sformatf("tbl%0d_new_pc", i), new_pc, tbl[i].e_pc);
    end
    id_r = 1'b0; ex_r = 1'b0; mem_r = 1'b0; fr = 1'b0;
    chk("tbl_no_timeout", {31'd0, tmo}, 32'h0);

    // watchdog: five consecutive EX stalls, then the flag must stick
    do_reset();
    ex_r = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tmo_after_%0d", k), {31'd0, tmo}, {31'd0, k == 5});
    end
    ex_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("tmo_sticky", {31'd0, tmo}, 32'h1);
    end

    // performance counter: 7 stall cycles then 2 idle
    do_reset();
    mem_r = 1'b1;
    repeat (7) @(posedge clk);
    #1; mem_r = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef STALL_PERF_COUNT_EN
    chk("perf_count", scyc, 32'd7);
`else
    chk("perf_count", scyc, 32'd0);
`endif

    // reset during the second flush cycle aborts the flush
    do_reset();
    fr = 1'b1; npc_i = 32'hAAAA0000;
    @(posedge clk); #1;
    fr = 1'b0;
    chk("abort_flush_c1", {31'd0, flush}, 32'h1);
    @(posedge clk); #1;
    chk("abort_flush_c2", {31'd0, flush}, 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_flush_now", {31'd0, flush}, 32'h0);
    chk("abort_new_pc", new_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("abort_no_flush", {31'd0, flush}, 32'h0);
    end

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      id_r  = ($urandom_range(0, 2) == 0);
      ex_r  = ($urandom_range(0, 2) == 0);
      mem_r = ($urandom_range(0, 3) == 0);
      fr    = ($urandom_range(0, 9) == 0);
      npc_i = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 16'd1023: consecutive-stall count that raises stall_timeout.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 3'd1: number of cycles flush is held (legal 1..7).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous reset, active-high (`RstEnable).
REQ-005 stallreq_from_id  in  1  ID-stage stall request (load-use hazard).
REQ-006 stallreq_from_ex  in  1  EX-stage stall request (multi-cycle op).
REQ-007 stallreq_from_mem  in  1  MEM-stage stall request (bus wait).
REQ-008 flush_req  in  1  exception/redirect request, sampled at posedge.
REQ-009 new_pc_i  in  32  redirect target accompanying flush_req.
REQ-010 stall  out  6  stall vector; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop.
REQ-011 flush  out  1  registered; clears all pipeline registers while 1.
REQ-012 new_pc  out  32  registered redirect target, valid while flush=1.
REQ-013 stall_timeout  out  1  sticky watchdog flag.
REQ-014 stall_cycles  out  32  stall performance counter (see Configuration).

Function
REQ-015 SHALL implement FSM states RUN and FLUSH, plus 3-bit flush_cnt.
REQ-016 RUN: flush_req=1 at posedge -> FLUSH, new_pc <= new_pc_i, flush_cnt <= FLUSH_CYCLES-1.
REQ-017 FLUSH: flush_cnt==0 -> RUN, else flush_cnt decrements; flush_req=1 in FLUSH re-latches new_pc_i and reloads flush_cnt (newest redirect wins).
REQ-018 flush SHALL equal (state==FLUSH), asserted from the cycle after flush_req sampled, for exactly FLUSH_CYCLES cycles absent re-requests.
REQ-019 stall SHALL be combinational from requests, priority mem > ex > id: mem 6'b011111, ex 6'b001111, id 6'b000111, none 6'b000000.
REQ-020 In FLUSH, stall SHALL be 6'b000000 regardless of requests.
REQ-021 Consecutive-stall counter (16 bit) SHALL increment each posedge with stall[0]=1, clear when stall[0]=0, saturate at 16'hFFFF.
REQ-022 stall_timeout SHALL set on the posedge the counter reaches STALL_LIMIT and remain 1 until reset.
REQ-023 Simultaneous flush_req and stall request in RUN: stall per REQ-019 this cycle; FSM still enters FLUSH next cycle.
REQ-024 stall[5] SHALL always be 0 (WB never stalled).

Reset
REQ-025 On rst=1 (asynchronous), SHALL force: state RUN, flush_cnt 0, flush 0, new_pc 32'h0, stall-run counter 0, stall_timeout 0, stall_cycles 32'h0.
REQ-026 While rst=1, stall SHALL read 6'b000000 regardless of requests.
REQ-027 Reset asserted mid-FLUSH SHALL abort the flush immediately; no flush pulse after release.

Configuration
REQ-028 Macro STALL_PERF_COUNT_EN defined: stall_cycles increments by 1 each posedge with stall[0]=1, wraps 32'hFFFFFFFF -> 0.
REQ-029 Macro undefined: stall_cycles port retained, driven constant 32'h0, no counter register instantiated.

Verification
REQ-030 Reset release, all requests 0 -> stall=6'b000000, flush=0, new_pc=0, stall_timeout=0.
REQ-031 stallreq_from_id=1 and stallreq_from_mem=1 together -> stall=6'b011111; drop mem -> 6'b000111 same cycle.
REQ-032 FLUSH_CYCLES=3, flush_req pulse with new_pc_i=32'hBFC00380, stallreq_from_ex=1 held -> next 3 cycles flush=1, new_pc=32'hBFC00380, stall=0; then stall=6'b001111.
REQ-033 STALL_LIMIT=5, stallreq_from_ex held 5 cycles -> stall_timeout=1 after 5th posedge, stays 1 after request drops.
REQ-034 STALL_PERF_COUNT_EN defined, 7 stall cycles then 2 idle -> stall_cycles=7; undefined -> stall_cycles=0.
REQ-035 rst asserted during second FLUSH cycle -> flush=0 immediately, new_pc=0, no flush after release.
